load_store_unit: RTL
====================

# load_store_unit

Initiator side of the CPU data-memory port. Accepts one load or store at a time from the MEM pipeline stage and drives the word-addressed data memory (32-bit words, combinational read, level-sensitive write). Performs byte-lane selection, sign/zero extension, and read-modify-write for sub-word stores. Reports misaligned and out-of-range accesses as errors without touching memory.

## Interface
- MEM_WORDS, 256: data memory depth in 32-bit words.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid: misaligned or out of range.
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors.
- mem_addr  out  32  word index (byte address >> 2, zero-extended).
- mem_wdata  out  32  word to write.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_rdata  in  32  memory read data, combinational from mem_addr.

## Operation
- FSM states: IDLE, RD, WR, DONE.
- IDLE: req_ready = 1. When req_valid is high, the unit latches we, size, unsigned, addr, and wdata.
  - Error check: half with addr[0] = 1, word with addr[1:0] ≠ 0, or addr[31:2] ≥ MEM_WORDS → DONE with err = 1.
  - Load or sub-word store → RD.
  - Word store → WR.
- RD: mem_read = 1 and mem_addr = word index. At the end of the cycle the unit captures mem_rdata.
  - Load → DONE with the extracted lane.
  - Store → WR with the merged word.
- WR: mem_write = 1 for exactly one cycle, with mem_addr and mem_wdata stable for the whole cycle → DONE.
- DONE: resp_valid = 1 for one cycle → IDLE. req_ready = 0 in every state except IDLE.
- Byte lanes are big-endian:
  - byte offset 0 = bits [31:24], offset 3 = bits [7:0];
  - half offset 0 = [31:16], half offset 2 = [15:0].
- Sub-word store merge: only the addressed lane is replaced with req_wdata[7:0] or [15:0]. Other lanes keep their values from the RD capture.
- Load extension: byte or half is extended to 32 bits by bit 7 or bit 15 when unsigned = 0, zero-filled otherwise.
- mem_read and mem_write are never high together. mem_addr, mem_wdata, mem_read, and mem_write come straight from flops, with no decode glitches, because the memory write is level-sensitive.

## Timing
- Request accepted at edge k:
  - misaligned / out of range: resp_valid in cycle k+1;
  - load or word store: resp_valid in cycle k+2;
  - sub-word store: resp_valid in cycle k+3.
- Throughput: the next request is accepted in the cycle after DONE, i.e. when back in IDLE.
- Reset values: state IDLE, req_ready = 1, all other outputs 0, all internal latches 0.
- Reset asserted mid-operation: mem_write and mem_read clear immediately (asynchronously). No response is issued for the aborted request. A sub-word store aborted in RD leaves memory untouched.
- req_* inputs are ignored outside IDLE; changes while busy have no effect.
- Error path: memory signals stay 0 for the whole request.

## Structure
- Shared package mips_mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state enum;
  - MEM_WORDS default.
- Sub-module lsu_lane_align (combinational) holds lane extract/extend for loads and lane merge for stores. The top holds the FSM and registers.

## Test plan
- Memory word 4 = 0x8899AABB; lw addr 0x10 → resp_rdata 0x8899AABB, err 0, resp_valid 2 cycles after accept.
- Same word, lb addr 0x11 → 0xFFFFFF99; lbu addr 0x11 → 0x00000099; lh addr 0x12 → 0xFFFFAABB.
- Memory word 4 = 0x11223344; sb addr 0x12, wdata 0x000000EE → one mem_read cycle, then one mem_write cycle with mem_wdata 0x1122EE44. Response arrives 3 cycles after accept.
- lh addr 0x13, then sw addr 0x3FC with MEM_WORDS = 255 → each gives resp_err 1 one cycle after accept. mem_read and mem_write stay 0 throughout.
- sw addr 0x20, data 0xDEADBEEF, with rst_n pulled low during WR → mem_write drops the same cycle, no resp_valid, state IDLE, req_ready 1 after release.
- Back-to-back requests with req_valid held high: second accepted only in IDLE. Changing req_addr while busy does not alter the in-flight access.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the CPU data-memory port: access sizes, LSU FSM states,
// and the default data memory depth.
package mips_mem_pkg;
    localparam int MEM_WORDS_DEFAULT = 256;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} lsu_state_e;
endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response handshake plus the word-addressed data memory bus.
// master = pipeline + memory side, slave = load_store_unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wdata, mem_read, mem_write
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Big-endian byte/half lane handling: extract + extend for loads, merge into the
// previously read word for sub-word stores.
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);
    // Offset 0 is the most significant lane, so the shift is (3 - offset) lanes.
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] mask;
    logic [31:0] ins;

    assign byte_sh = {~offset, 3'b000};
    assign half_sh = {~offset[1], 4'b0000};
    assign lane_b  = 8'(word >> byte_sh);
    assign lane_h  = 16'(word >> half_sh);

    always_comb begin
        load_data = word;
        mask      = 32'hFFFF_FFFF;
        ins       = wdata;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
                mask      = 32'h0000_00FF << byte_sh;
                ins       = {24'h0, wdata[7:0]} << byte_sh;
            end
            SZ_HALF: begin
                load_data = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
                mask      = 32'h0000_FFFF << half_sh;
                ins       = {16'h0, wdata[15:0]} << half_sh;
            end
            default: ;
        endcase
        store_word = (word & ~mask) | ins;
    end
endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, read-modify-write for sub-word
// stores, misaligned/out-of-range accesses answered with an error and no memory traffic.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);
    lsu_state_e  state, state_n;
    logic        we_q, uns_q, err_q, err_n;
    logic [1:0]  size_q, off_q;
    logic [31:0] wdata_q, rdata_q, rdata_n;
    logic [31:0] mem_addr_q, mem_addr_n, mem_wdata_q, mem_wdata_n;
    logic        mem_read_q, mem_read_n, mem_write_q, mem_write_n;
    logic        accept, sub_word, bad;
    logic [31:0] load_data, store_word;

    assign sub_word = (bus.req_size == SZ_BYTE) || (bus.req_size == SZ_HALF);
    assign bad = (bus.req_size == SZ_HALF && bus.req_addr[0])
              || (!sub_word && bus.req_addr[1:0] != 2'b00)
              || ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS));

    lsu_lane_align u_align (
        .size       (size_q),
        .offset     (off_q),
        .is_unsigned(uns_q),
        .word       (bus.mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Memory strobes are next-state decoded here and registered below, so the
    // level-sensitive write enable never sees combinational glitches.
    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        err_n       = err_q;
        rdata_n     = rdata_q;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;
        mem_read_n  = 1'b0;
        mem_write_n = 1'b0;
        case (state)
            IDLE: if (bus.req_valid) begin
                accept  = 1'b1;
                err_n   = bad;
                rdata_n = '0;
                if (bad) begin
                    state_n = DONE;
                end else if (!bus.req_we || sub_word) begin
                    state_n    = RD;
                    mem_read_n = 1'b1;
                    mem_addr_n = {2'b00, bus.req_addr[31:2]};
                end else begin
                    state_n     = WR;
                    mem_write_n = 1'b1;
                    mem_addr_n  = {2'b00, bus.req_addr[31:2]};
                    mem_wdata_n = bus.req_wdata;
                end
            end
            RD: if (we_q) begin
                state_n     = WR;
                mem_write_n = 1'b1;
                mem_wdata_n = store_word;
            end else begin
                state_n = DONE;
                rdata_n = load_data;
            end
            WR: state_n = DONE;
            DONE: begin
                state_n     = IDLE;
                err_n       = 1'b0;
                rdata_n     = '0;
                mem_addr_n  = '0;
                mem_wdata_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                size_q  <= bus.req_size;
                off_q   <= bus.req_addr[1:0];
                wdata_q <= bus.req_wdata;
            end
            err_q       <= err_n;
            rdata_q     <= rdata_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
            mem_read_q  <= mem_read_n;
            mem_write_q <= mem_write_n;
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == DONE);
    assign bus.resp_err   = err_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
endmodule
